alu_issue_stage: RTL

//  Issue/writeback stage wrapped around the combinational ALU. Accepts one instruction per

---
 rtl/alu_issue_stage.sv | 120 ++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of a combinational ALU.
// Holds one instruction in an EX slot, drives the ALU operands and controls
// from the slot, and commits the ALU result and C/Z flags on the output handshake.
module alu_issue_stage #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int RA   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RA-1:0]    in_rd,
  input  logic [RA-1:0]    in_rs,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RA-1:0]    out_rd,
  output logic             flag_c,
  output logic             flag_z,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ci,
  output logic             alu_nb,
  output logic             alu_ic,
  output logic             alu_na,
  output logic             alu_xo,
  output logic             alu_no,
  output logic             alu_rot,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_cf
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR  = 3'd4, OP_XOR = 3'd5, OP_ROT = 3'd6, OP_MOV = 3'd7;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t                       state;
  logic [2:0]                   s_op;
  logic [RA-1:0]                s_rd, s_rs;
  logic                         s_use_imm;
  logic [WIDTH-1:0]             s_imm;
  logic [NREGS-1:0][WIDTH-1:0]  regs;
  logic                         in_fire, out_fire;

  assign out_valid = (state == EXEC);
  assign in_ready  = ~out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = alu_o;
  assign out_rd    = s_rd;

  // Slot FSM: refill on accept, drain to IDLE when the result leaves with no new op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_op      <= OP_ADD;
      s_rd      <= '0;
      s_rs      <= '0;
      s_use_imm <= 1'b0;
      s_imm     <= '0;
    end else if (in_fire) begin
      state     <= EXEC;
      s_op      <= in_op;
      s_rd      <= in_rd;
      s_rs      <= in_rs;
      s_use_imm <= in_use_imm;
      s_imm     <= in_imm;
    end else if (out_fire) begin
      state     <= IDLE;
    end
  end

  // Writeback of result and flags; carry only tracks the arithmetic ops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs   <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (out_fire) begin
      regs[s_rd] <= alu_o;
      flag_z     <= (alu_o == '0);
      if (s_op == OP_ADD || s_op == OP_ADC || s_op == OP_SUB)
        flag_c <= alu_cf;
    end
  end

  // Operand read and opcode decode; everything quiet while the slot is empty
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ci  = 1'b0;
    alu_nb  = 1'b0;
    alu_ic  = 1'b0;
    alu_na  = 1'b0;
    alu_xo  = 1'b0;
    alu_no  = 1'b0;
    alu_rot = 1'b0;
    if (state == EXEC) begin
      alu_a = (s_op == OP_MOV) ? '0 : regs[s_rd];
      alu_b = s_use_imm ? s_imm : regs[s_rs];
      case (s_op)
        OP_ADD: ;
        OP_ADC: alu_ci = flag_c;
        OP_SUB: begin alu_ci = 1'b1; alu_nb = 1'b1; end
        OP_AND: begin alu_nb = 1'b1; alu_ic = 1'b1; alu_na = 1'b1; alu_xo = 1'b1; alu_no = 1'b1; end
        OP_OR:  begin alu_ic = 1'b1; alu_xo = 1'b1; end
        OP_XOR: alu_ic = 1'b1;
        OP_ROT: alu_rot = 1'b1;
        OP_MOV: alu_ic = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
